seq11011_tx: RTL and testbench
==============================

SEQ11011_TX -- requirements
Module: seq11011_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 8, payload bits per frame.
REQ-002 SHALL have parameter SYNC_WORD, default 5'b11011, sync pattern sent MSB first.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  PAYLOAD_W  payload word to send.
REQ-006 SHALL have port load  input  1  payload valid, qualified by ready.
REQ-007 SHALL have port ready  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port out  output  1  serial bit stream.
REQ-009 SHALL have port out_en  output  1  out carries a frame bit this cycle.
REQ-010 SHALL have port frame_done  output  1  high during the last bit (parity) of a frame.

Function
REQ-011 SHALL be a Moore machine: out, out_en, ready and frame_done are functions of registered state only, never of load or data_in.
REQ-012 SHALL implement the states IDLE, SYNC, DATA and PAR.
REQ-013 SHALL define one transfer as load=1 and ready=1 on the same rising edge; data_in SHALL then be captured into an internal shift register.
REQ-014 SHALL drive ready=1 in IDLE and in PAR, and ready=0 in SYNC and DATA.
REQ-015 SHALL ignore load while ready=0: no capture, no state change.
REQ-016 SHALL, on a transfer, enter SYNC on the next cycle; first frame bit on out one cycle after the accepting edge.
REQ-017 SHALL emit in SYNC the 5 SYNC_WORD bits, MSB first, one per cycle, then enter DATA.
REQ-018 SHALL emit in DATA the PAYLOAD_W captured bits, MSB first, one per cycle, then enter PAR.
REQ-019 SHALL emit in PAR one even-parity bit (XOR of all payload bits); frame length SHALL be 5+PAYLOAD_W+1 cycles (14 at default).
REQ-020 SHALL, from PAR, enter SYNC if a transfer occurs in that cycle (back-to-back, no gap), else enter IDLE.
REQ-021 SHALL hold out_en=1 in SYNC, DATA and PAR, and out_en=0 in IDLE.
REQ-022 SHALL hold out=0 in IDLE.
REQ-023 SHALL hold frame_done=1 only in PAR.
REQ-024 SHALL use a bit counter of width clog2(max(5,PAYLOAD_W)) that clears on every state entry; no wrap-around beyond the terminal count.

Reset
REQ-025 SHALL, on rst=0 and regardless of clk, force state=IDLE, counter=0, shift register=0, out=0, out_en=0, frame_done=0 and ready=1.
REQ-026 SHALL abort any frame in progress when reset asserts mid-frame; no partial bits after release.
REQ-027 SHALL begin a transfer on the first rising edge after reset release at the earliest.

Structure
REQ-028 SHALL place the state encoding, default SYNC_WORD and frame-length constant in a shared package with the sequence detectors.
REQ-029 SHALL contain a single sub-module, seq11011_shreg: loadable MSB-first shift register with parity accumulate.

Verification
REQ-030 SHALL verify single frame: load data_in=8'hA5 once -> out=1,1,0,1,1,1,0,1,0,0,1,0,1,0 over 14 cycles, out_en=1 throughout, frame_done in cycle 14 only.
REQ-031 SHALL verify back-to-back frames: 8'hFF then 8'h00, second loaded during PAR -> 28 consecutive out_en=1 cycles; both parity bits 0.
REQ-032 SHALL verify busy rejection: load=1 with 8'h3C during the DATA state of a frame carrying 8'hA5 -> A5 frame unchanged; 3C never sent.
REQ-033 SHALL verify reset mid-frame: rst=0 in cycle 7 of a frame -> out=0, out_en=0, ready=1 immediately; next frame after release is complete and correct.
REQ-034 SHALL verify loopback: out feeds a 11011 overlapping Moore detector with payload 8'h00 -> exactly one detector pulse per frame, one cycle after the fifth sync bit.

Source files
------------

// File: rtl/seq11011_pkg.sv
// Shared definitions for the 11011 sync-word transmitter and the matching sequence detectors.
package seq11011_pkg;

   localparam int unsigned SYNC_LEN      = 5;
   localparam logic [SYNC_LEN-1:0] SYNC_WORD_DEF = 5'b11011;
   localparam int unsigned PAYLOAD_W_DEF = 8;
   localparam int unsigned FRAME_LEN_DEF = SYNC_LEN + PAYLOAD_W_DEF + 1;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA,
      PAR
   } tx_state_e;

   // Overlapping 11011 detector states: each name is the longest matched prefix.
   typedef enum logic [2:0] {
      DET_S0,
      DET_S1,
      DET_S11,
      DET_S110,
      DET_S1101,
      DET_HIT
   } det_state_e;

   // Bit at position pos of word, counted from the MSB; 0 once past the end.
   function automatic logic sync_bit(input logic [SYNC_LEN-1:0] word, input int unsigned pos);
      logic [SYNC_LEN-1:0] w;
      w = word << pos;
      return w[SYNC_LEN-1];
   endfunction

endpackage

// File: rtl/seq11011_shreg.sv
// Loadable MSB-first payload shift register that accumulates even parity of the bits shifted out.
module seq11011_shreg
   import seq11011_pkg::*;
#(
   parameter int unsigned W = PAYLOAD_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb,
   output logic         parity
);

   logic [W-1:0] sreg_q, sreg_d;
   logic         par_q, par_d;

   always_comb begin
      sreg_d = sreg_q;
      par_d  = par_q;
      if (load) begin
         sreg_d = din;
         par_d  = 1'b0;
      end else if (shift) begin
         sreg_d = sreg_q << 1;
         par_d  = par_q ^ sreg_q[W-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         par_q  <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         par_q  <= par_d;
      end
   end

   assign msb    = sreg_q[W-1];
   assign parity = par_q;

endmodule

// File: rtl/seq11011_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, even parity; Moore outputs, all registered.
module seq11011_tx
   import seq11011_pkg::*;
#(
   parameter int unsigned          PAYLOAD_W = PAYLOAD_W_DEF,
   parameter logic [SYNC_LEN-1:0]  SYNC_WORD = SYNC_WORD_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PAYLOAD_W-1:0] data_in,
   input  logic                 load,
   output logic                 ready,
   output logic                 out,
   output logic                 out_en,
   output logic                 frame_done
);

   localparam int unsigned CNT_MAX = (PAYLOAD_W > SYNC_LEN) ? PAYLOAD_W : SYNC_LEN;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             out_en_q, out_en_d;
   logic             ready_q, ready_d;
   logic             frame_done_q, frame_done_d;
   logic             sh_load, sh_shift, sh_msb, sh_par;
   logic             xfer;

   assign xfer = load & ready_q;

   seq11011_shreg #(.W(PAYLOAD_W)) u_shreg (
      .clk    (clk),
      .rst_n  (rst),
      .load   (sh_load),
      .shift  (sh_shift),
      .din    (data_in),
      .msb    (sh_msb),
      .parity (sh_par)
   );

   // Outputs are computed for the state being entered, so each bit appears the cycle after its edge.
   // The shift register advances whenever its MSB is taken, so parity is complete on entering PAR.
   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      out_d        = 1'b0;
      out_en_d     = 1'b0;
      ready_d      = 1'b0;
      frame_done_d = 1'b0;
      sh_load      = 1'b0;
      sh_shift     = 1'b0;
      unique case (state_q)
         IDLE, PAR: begin
            if (xfer) begin
               state_d  = SYNC;
               sh_load  = 1'b1;
               out_d    = SYNC_WORD[SYNC_LEN-1];
               out_en_d = 1'b1;
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end
         SYNC: begin
            out_en_d = 1'b1;
            if (cnt_q == CNT_W'(SYNC_LEN - 1)) begin
               state_d  = DATA;
               out_d    = sh_msb;
               sh_shift = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               out_d = sync_bit(SYNC_WORD, 32'(cnt_q) + 32'd1);
            end
         end
         DATA: begin
            out_en_d = 1'b1;
            if (cnt_q == CNT_W'(PAYLOAD_W - 1)) begin
               state_d      = PAR;
               out_d        = sh_par;
               ready_d      = 1'b1;
               frame_done_d = 1'b1;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               out_d    = sh_msb;
               sh_shift = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         out_q        <= 1'b0;
         out_en_q     <= 1'b0;
         ready_q      <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         out_q        <= out_d;
         out_en_q     <= out_en_d;
         ready_q      <= ready_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign ready      = ready_q;
   assign out        = out_q;
   assign out_en     = out_en_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq11011_tx.sv
// Bench for seq11011_tx: queue-based frame model checked every cycle, plus literal frame checks.
module tb_seq11011_tx;

   localparam int PW   = 8;
   localparam int LOGN = 8192;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          load    = 1'b0;
   logic [PW-1:0] data_in = '0;
   logic          ready, out, out_en, frame_done;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   seq11011_tx #(.PAYLOAD_W(PW), .SYNC_WORD(5'b11011)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .load       (load),
      .ready      (ready),
      .out        (out),
      .out_en     (out_en),
      .frame_done (frame_done)
   );

   task automatic check(input string nm, input logic act, input logic exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", nm, cyc, act, exp);
      end
   endtask

   // Model: a queue of frame bits still to be sent plus the bit currently on the line.
   bit   rem[$];
   logic m_valid = 1'b0;
   logic m_bit   = 1'b0;
   logic m_last  = 1'b0;

   task automatic push_frame(input logic [PW-1:0] d);
      logic [4:0] sw;
      sw = 5'b11011;
      for (int i = 4; i >= 0; i--) rem.push_back(sw[i]);
      for (int i = PW - 1; i >= 0; i--) rem.push_back(d[i]);
      rem.push_back(^d);
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem.delete();
         m_valid <= 1'b0;
         m_bit   <= 1'b0;
         m_last  <= 1'b0;
      end else begin
         if ((!m_valid || m_last) && load) push_frame(data_in);
         if (rem.size() != 0) begin
            m_bit   <= rem.pop_front();
            m_valid <= 1'b1;
            m_last  <= (rem.size() == 0);
         end else begin
            m_valid <= 1'b0;
            m_bit   <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("out", out, m_valid & m_bit);
         check("out_en", out_en, m_valid);
         check("frame_done", frame_done, m_valid & m_last);
         check("ready", ready, !m_valid | m_last);
      end
   end

   // Overlapping 11011 detector on the serial line, pulse registered after the match.
   logic [4:0] hist;
   logic       det;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         det  <= 1'b0;
      end else begin
         hist <= {hist[3:0], out};
         det  <= ({hist[3:0], out} == 5'b11011);
      end
   end

   logic lg_out [LOGN];
   logic lg_en  [LOGN];
   logic lg_fd  [LOGN];
   logic lg_det [LOGN];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LOGN) begin
         lg_out[cyc] <= out;
         lg_en[cyc]  <= out_en;
         lg_fd[cyc]  <= frame_done;
         lg_det[cyc] <= det;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (!(ready && !out_en) && n < 100) begin
         tick();
         n++;
      end
      check(nm, ready && !out_en, 1'b1);
   endtask

   // Sends n frames back to back, each next payload offered during the previous PAR cycle.
   task automatic send_frames(input int n, input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                              input logic [PW-1:0] d2, output int c0);
      logic [PW-1:0] d [3];
      d[0] = d0;
      d[1] = d1;
      d[2] = d2;
      c0 = cyc;
      for (int f = 0; f < n; f++) begin
         data_in = d[f];
         load    = 1'b1;
         tick();
         load    = 1'b0;
         data_in = PW'($urandom);
         repeat (13) tick();
      end
      repeat (3) tick();
   endtask

   task automatic check_frame(input string nm, input int c0, input logic [13:0] bits);
      for (int k = 1; k <= 14; k++) begin
         check({nm, "_out"}, lg_out[c0+k], bits[14-k]);
         check({nm, "_en"}, lg_en[c0+k], 1'b1);
         check({nm, "_done"}, lg_fd[c0+k], k == 14);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [13:0] a5_bits, ff_bits, z_bits;
      int c0, p;
      a5_bits = 14'b11011101001010;
      ff_bits = 14'b11011111111110;
      z_bits  = 14'b11011000000000;

      // Asynchronous reset, observed before any clock edge.
      #2 rst = 1'b0;
      #1;
      check("rst_out", out, 1'b0);
      check("rst_out_en", out_en, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_ready", ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      wait_idle("idle_a5");
      send_frames(1, 8'hA5, 8'h00, 8'h00, c0);
      check_frame("a5", c0, a5_bits);
      check("a5_tail_en", lg_en[c0+15], 1'b0);

      wait_idle("idle_b2b");
      send_frames(2, 8'hFF, 8'h00, 8'h00, c0);
      check_frame("ff", c0, ff_bits);
      check_frame("z", c0 + 14, z_bits);
      check("b2b_tail_en", lg_en[c0+29], 1'b0);

      // Load offered during DATA must be ignored and dropped before PAR.
      wait_idle("idle_busy");
      c0 = cyc;
      data_in = 8'hA5;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      repeat (7) tick();
      data_in = 8'h3C;
      load    = 1'b1;
      repeat (2) tick();
      load    = 1'b0;
      repeat (10) tick();
      check_frame("busy", c0, a5_bits);
      for (int k = 15; k <= 20; k++) check("busy_no3c_en", lg_en[c0+k], 1'b0);

      // Reset mid-frame, then a transfer on the first edge after release.
      wait_idle("idle_rst");
      data_in = 8'hA5;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      repeat (6) tick();
      #2 rst = 1'b0;
      #1;
      check("midrst_out", out, 1'b0);
      check("midrst_out_en", out_en, 1'b0);
      check("midrst_ready", ready, 1'b1);
      check("midrst_done", frame_done, 1'b0);
      tick();
      tick();
      rst     = 1'b1;
      data_in = 8'hA5;
      load    = 1'b1;
      c0      = cyc;
      tick();
      load    = 1'b0;
      repeat (16) tick();
      check_frame("postrst", c0, a5_bits);

      // Loopback into the detector: one pulse per all-zero frame.
      wait_idle("idle_loop");
      send_frames(3, 8'h00, 8'h00, 8'h00, c0);
      p = 0;
      for (int k = 1; k <= 44; k++) p += int'(lg_det[c0+k]);
      check("det_f1", lg_det[c0+6], 1'b1);
      check("det_f2", lg_det[c0+20], 1'b1);
      check("det_f3", lg_det[c0+34], 1'b1);
      check("det_count_is_3", p == 3, 1'b1);

      // Random traffic with occasional asynchronous resets.
      repeat (2500) begin
         load    = ($urandom_range(0, 2) == 0);
         data_in = PW'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b0;
            tick();
            tick();
            rst = 1'b1;
         end
         tick();
      end
      load = 1'b0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
